// File: rtl/scr1_dmem_router_pkg.sv
// Shared memory-interface types and port 1 address map for the DMEM router.
// The SoC top imports the same decode constants so both sides agree on the map.
package scr1_dmem_router_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_IDLE   = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_PORT1_MASK    = 32'hFFFF_0000;
    localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_PORT1_PATTERN = 32'h0048_0000;

    // Copy the LSB-aligned store operand onto every byte lane it may occupy.
    function automatic logic [SCR1_DMEM_DWIDTH-1:0] scr1_replicate_wdata(
        input type_scr1_mem_width_e  width,
        input logic [SCR1_DMEM_DWIDTH-1:0] wdata
    );
        logic [SCR1_DMEM_DWIDTH-1:0] res;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  res = {4{wdata[7:0]}};
            SCR1_MEM_WIDTH_HWORD: res = {2{wdata[15:0]}};
            default:              res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/scr1_dmem_router.sv
// Routes LSU data-memory requests to one of two targets by address decode,
// tracking the single outstanding transaction and aligning load/store data.
module scr1_dmem_router
    import scr1_dmem_router_pkg::*;
#(
    parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT1_ADDR_MASK    = SCR1_DMEM_PORT1_MASK,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT1_ADDR_PATTERN = SCR1_DMEM_PORT1_PATTERN
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        dmem_req,
    input  type_scr1_mem_cmd_e          dmem_cmd,
    input  type_scr1_mem_width_e        dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic                        dmem_req_ack,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e         dmem_resp,

    output logic                        port0_req,
    output type_scr1_mem_cmd_e          port0_cmd,
    output type_scr1_mem_width_e        port0_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] port0_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0] port0_wdata,
    input  logic                        port0_req_ack,
    input  logic [SCR1_DMEM_DWIDTH-1:0] port0_rdata,
    input  type_scr1_mem_resp_e         port0_resp,

    output logic                        port1_req,
    output type_scr1_mem_cmd_e          port1_cmd,
    output type_scr1_mem_width_e        port1_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] port1_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0] port1_wdata,
    input  logic                        port1_req_ack,
    input  logic [SCR1_DMEM_DWIDTH-1:0] port1_rdata,
    input  type_scr1_mem_resp_e         port1_resp
);

    typedef enum logic {
        SCR1_FSM_IDLE,
        SCR1_FSM_WAIT
    } type_scr1_fsm_e;

    type_scr1_fsm_e              fsm;
    logic                        sel_r;
    logic [1:0]                  addr_lo_r;

    logic                        sel1;
    logic                        can_issue;
    type_scr1_mem_resp_e         sel_resp;
    logic [SCR1_DMEM_DWIDTH-1:0] sel_rdata;
    logic [SCR1_DMEM_DWIDTH-1:0] wdata_rep;

    assign sel1 = ((dmem_addr & SCR1_PORT1_ADDR_MASK) == SCR1_PORT1_ADDR_PATTERN);

    always_comb begin
        sel_resp  = sel_r ? port1_resp  : port0_resp;
        sel_rdata = sel_r ? port1_rdata : port0_rdata;
    end

    // A completing response frees the slot in the same cycle, allowing back-to-back issue.
    always_comb begin
        can_issue = (fsm == SCR1_FSM_IDLE)
                  | ((fsm == SCR1_FSM_WAIT) & (sel_resp != SCR1_MEM_RESP_IDLE));
        port0_req = dmem_req & can_issue & ~sel1;
        port1_req = dmem_req & can_issue &  sel1;
        dmem_req_ack = sel1 ? (port1_req_ack & port1_req) : (port0_req_ack & port0_req);
    end

    always_comb begin
        wdata_rep   = scr1_replicate_wdata(dmem_width, dmem_wdata);
        port0_cmd   = dmem_cmd;
        port1_cmd   = dmem_cmd;
        port0_width = dmem_width;
        port1_width = dmem_width;
        port0_addr  = dmem_addr;
        port1_addr  = dmem_addr;
        port0_wdata = wdata_rep;
        port1_wdata = wdata_rep;
    end

    // Only the port owning the outstanding transaction may answer; everything else reads as IDLE.
    always_comb begin
        dmem_resp  = SCR1_MEM_RESP_IDLE;
        dmem_rdata = '0;
        if (fsm == SCR1_FSM_WAIT && sel_resp != SCR1_MEM_RESP_IDLE) begin
            dmem_resp  = sel_resp;
            dmem_rdata = sel_rdata >> {addr_lo_r, 3'b000};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= SCR1_FSM_IDLE;
            sel_r     <= 1'b0;
            addr_lo_r <= 2'b00;
        end else if (dmem_req_ack) begin
            fsm       <= SCR1_FSM_WAIT;
            sel_r     <= sel1;
            addr_lo_r <= dmem_addr[1:0];
        end else if (fsm == SCR1_FSM_WAIT && sel_resp != SCR1_MEM_RESP_IDLE) begin
            fsm       <= SCR1_FSM_IDLE;
        end
    end

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Directed self-checking bench for scr1_dmem_router.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_scr1_dmem_router;
    import scr1_dmem_router_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 dmem_req;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [31:0]          dmem_addr;
    logic [31:0]          dmem_wdata;
    logic                 dmem_req_ack;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;

    logic                 port0_req, port1_req;
    type_scr1_mem_cmd_e   port0_cmd, port1_cmd;
    type_scr1_mem_width_e port0_width, port1_width;
    logic [31:0]          port0_addr, port1_addr;
    logic [31:0]          port0_wdata, port1_wdata;
    logic                 port0_req_ack, port1_req_ack;
    logic [31:0]          port0_rdata, port1_rdata;
    type_scr1_mem_resp_e  port0_resp, port1_resp;

    int tests_run  = 0;
    int fail_count = 0;

    scr1_dmem_router dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dmem_req      (dmem_req),
        .dmem_cmd      (dmem_cmd),
        .dmem_width    (dmem_width),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_req_ack  (dmem_req_ack),
        .dmem_rdata    (dmem_rdata),
        .dmem_resp     (dmem_resp),
        .port0_req     (port0_req),
        .port0_cmd     (port0_cmd),
        .port0_width   (port0_width),
        .port0_addr    (port0_addr),
        .port0_wdata   (port0_wdata),
        .port0_req_ack (port0_req_ack),
        .port0_rdata   (port0_rdata),
        .port0_resp    (port0_resp),
        .port1_req     (port1_req),
        .port1_cmd     (port1_cmd),
        .port1_width   (port1_width),
        .port1_addr    (port1_addr),
        .port1_wdata   (port1_wdata),
        .port1_req_ack (port1_req_ack),
        .port1_rdata   (port1_rdata),
        .port1_resp    (port1_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input type_scr1_mem_cmd_e cmd,
                                 input type_scr1_mem_width_e width,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        dmem_req   = req;
        dmem_cmd   = cmd;
        dmem_width = width;
        dmem_addr  = addr;
        dmem_wdata = wdata;
    endtask

    task automatic idlePorts();
        dmem_req      = 1'b0;
        port0_req_ack = 1'b0;
        port1_req_ack = 1'b0;
        port0_resp    = SCR1_MEM_RESP_IDLE;
        port1_resp    = SCR1_MEM_RESP_IDLE;
        port0_rdata   = 32'h0;
        port1_rdata   = 32'h0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        #0;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        idlePorts();
        tick();
        tick();
        rst_n = 1'b1;
        #2;
        checkOutput("rst_p0_req", 32'(port0_req), 32'd0);
        checkOutput("rst_p1_req", 32'(port1_req), 32'd0);
        checkOutput("rst_ack", 32'(dmem_req_ack), 32'd0);
        checkOutput("rst_resp", 32'(dmem_resp), 32'd0);
        checkOutput("rst_rdata", dmem_rdata, 32'h0);

        // Word read from port 0, response two cycles after accept
        applyStimulus(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0000_1000, 32'h0);
        port0_req_ack = 1'b1;
        #2;
        checkOutput("rd0_p0_req", 32'(port0_req), 32'd1);
        checkOutput("rd0_p1_req", 32'(port1_req), 32'd0);
        checkOutput("rd0_ack", 32'(dmem_req_ack), 32'd1);
        tick();
        idlePorts();
        #2;
        checkOutput("rd0_wait_resp", 32'(dmem_resp), 32'd0);
        tick();
        port0_resp  = SCR1_MEM_RESP_RDY_OK;
        port0_rdata = 32'hDEAD_BEEF;
        #2;
        checkOutput("rd0_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
        checkOutput("rd0_rdata", dmem_rdata, 32'hDEAD_BEEF);
        tick();
        #2;
        checkOutput("rd0_idle_stray", 32'(dmem_resp), 32'd0);
        checkOutput("rd0_idle_rdata", dmem_rdata, 32'h0);
        idlePorts();

        // Byte read from port 1 at offset 3
        applyStimulus(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h0048_0003, 32'h0);
        port1_req_ack = 1'b1;
        #2;
        checkOutput("rdb_p1_req", 32'(port1_req), 32'd1);
        checkOutput("rdb_p0_req", 32'(port0_req), 32'd0);
        checkOutput("rdb_ack", 32'(dmem_req_ack), 32'd1);
        tick();
        idlePorts();
        port1_resp  = SCR1_MEM_RESP_RDY_OK;
        port1_rdata = 32'h1122_3344;
        port0_resp  = SCR1_MEM_RESP_RDY_ER;
        #2;
        checkOutput("rdb_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
        checkOutput("rdb_rdata", dmem_rdata, 32'h0000_0011);
        tick();
        idlePorts();

        // Halfword write to port 1
        applyStimulus(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h0048_0002, 32'h1234_ABCD);
        port1_req_ack = 1'b1;
        #2;
        checkOutput("wrh_p1_wdata", port1_wdata, 32'hABCD_ABCD);
        checkOutput("wrh_p0_wdata", port0_wdata, 32'hABCD_ABCD);
        checkOutput("wrh_p1_width", 32'(port1_width), 32'(SCR1_MEM_WIDTH_HWORD));
        checkOutput("wrh_p1_cmd", 32'(port1_cmd), 32'(SCR1_MEM_CMD_WR));
        checkOutput("wrh_p1_addr", port1_addr, 32'h0048_0002);
        tick();
        idlePorts();
        port1_resp = SCR1_MEM_RESP_RDY_OK;
        #2;
        checkOutput("wrh_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
        tick();
        idlePorts();

        // Byte write to port 0 held one cycle without ack
        applyStimulus(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h0000_2001, 32'h0000_005A);
        #2;
        checkOutput("wrb_hold_req", 32'(port0_req), 32'd1);
        checkOutput("wrb_hold_ack", 32'(dmem_req_ack), 32'd0);
        checkOutput("wrb_wdata", port0_wdata, 32'h5A5A_5A5A);
        tick();
        #2;
        checkOutput("wrb_hold2_req", 32'(port0_req), 32'd1);
        port0_req_ack = 1'b1;
        #2;
        checkOutput("wrb_ack", 32'(dmem_req_ack), 32'd1);
        tick();
        idlePorts();
        port0_resp  = SCR1_MEM_RESP_RDY_OK;
        port0_rdata = 32'h0000_AA00;
        #2;
        checkOutput("wrb_rdata_shift", dmem_rdata, 32'h0000_00AA);
        tick();
        idlePorts();

        // Back-to-back: port 0 completes while a port 1 request is accepted
        applyStimulus(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0000_3000, 32'h0);
        port0_req_ack = 1'b1;
        tick();
        idlePorts();
        applyStimulus(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0048_0000, 32'h0);
        #2;
        checkOutput("b2b_blocked_req", 32'(port1_req), 32'd0);
        port1_req_ack = 1'b1;
        port0_resp    = SCR1_MEM_RESP_RDY_OK;
        port0_rdata   = 32'h1234_5678;
        #2;
        checkOutput("b2b_p1_req", 32'(port1_req), 32'd1);
        checkOutput("b2b_ack", 32'(dmem_req_ack), 32'd1);
        checkOutput("b2b_resp0", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
        checkOutput("b2b_rdata0", dmem_rdata, 32'h1234_5678);
        tick();
        idlePorts();
        port0_resp  = SCR1_MEM_RESP_RDY_OK;
        port0_rdata = 32'hFFFF_FFFF;
        #2;
        checkOutput("b2b_stray_resp", 32'(dmem_resp), 32'd0);
        checkOutput("b2b_stray_rdata", dmem_rdata, 32'h0);
        tick();
        idlePorts();
        port1_resp  = SCR1_MEM_RESP_RDY_OK;
        port1_rdata = 32'hCAFE_F00D;
        #2;
        checkOutput("b2b_resp1", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
        checkOutput("b2b_rdata1", dmem_rdata, 32'hCAFE_F00D);
        tick();
        idlePorts();

        // Error response from port 0
        applyStimulus(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0000_4000, 32'h0);
        port0_req_ack = 1'b1;
        tick();
        idlePorts();
        port0_resp  = SCR1_MEM_RESP_RDY_ER;
        port0_rdata = 32'hFFFF_0000;
        #2;
        checkOutput("err_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_ER));
        tick();
        idlePorts();
        port0_resp = SCR1_MEM_RESP_RDY_OK;
        #2;
        checkOutput("err_back_idle", 32'(dmem_resp), 32'd0);
        idlePorts();

        // Reset while waiting on port 1, then a stray response afterwards
        applyStimulus(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0048_0004, 32'h0);
        port1_req_ack = 1'b1;
        tick();
        idlePorts();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        port1_resp = SCR1_MEM_RESP_RDY_OK;
        port0_resp = SCR1_MEM_RESP_RDY_OK;
        #2;
        checkOutput("rstw_resp", 32'(dmem_resp), 32'd0);
        checkOutput("rstw_rdata", dmem_rdata, 32'h0);
        tick();
        idlePorts();
        applyStimulus(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0000_6000, 32'h0);
        port0_req_ack = 1'b1;
        #2;
        checkOutput("rstw_new_req", 32'(port0_req), 32'd1);
        checkOutput("rstw_new_ack", 32'(dmem_req_ack), 32'd1);
        tick();
        idlePorts();
        port0_resp  = SCR1_MEM_RESP_RDY_OK;
        port0_rdata = 32'h0000_0055;
        #2;
        checkOutput("rstw_new_rdata", dmem_rdata, 32'h0000_0055);
        tick();
        idlePorts();

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
